// File: rtl/frame_demap_pkg.sv
// Shared constants for the frame demapper: alignment FSM encoding and the
// row CRC-8 (poly 0x07, MSB-first, no reflection, no final XOR).
package frame_demap_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_HUNT    = 2'd0;
  localparam fsm_state_t ST_PRESYNC = 2'd1;
  localparam fsm_state_t ST_SYNC    = 2'd2;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  // One byte of CRC-8 update: fold the byte in, then eight MSB-first shifts.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_pos_sync.sv
// Frame position counter plus the HUNT/PRESYNC/SYNC alignment FSM with
// lock (SYNC_M) and loss (LOSS_N) hysteresis. o_row/o_col address the next byte.
module frame_pos_sync
  import frame_demap_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 1024,
  parameter int SYNC_M = 2,
  parameter int LOSS_N = 3,
  parameter int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W  = $clog2(COLS)
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_fas,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_sync
);

  localparam int GOOD_W = (SYNC_M > 1) ? $clog2(SYNC_M + 1) : 1;
  localparam int MISS_W = (LOSS_N > 1) ? $clog2(LOSS_N + 1) : 1;

  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(SYNC_M);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_N);

  fsm_state_t        r_state;
  logic [GOOD_W-1:0] r_good;
  logic [MISS_W-1:0] r_miss;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;

  fsm_state_t        w_state_nxt;
  logic [GOOD_W-1:0] w_good_nxt;
  logic [MISS_W-1:0] w_miss_nxt;
  logic              w_advance;
  logic              w_at_start;

  assign w_at_start = (r_row == '0) && (r_col == '0);

  // w_advance low on a valid byte means the counter snaps back to (0,0).
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_advance   = 1'b0;
    if (i_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (i_fas) begin
            w_advance   = 1'b1;
            w_good_nxt  = GOOD_W'(1);
            w_miss_nxt  = '0;
            w_state_nxt = (SYNC_M == 1) ? ST_SYNC : ST_PRESYNC;
          end
        end
        ST_PRESYNC: begin
          if (w_at_start && i_fas) begin
            w_advance  = 1'b1;
            w_good_nxt = r_good + 1'b1;
            if ((r_good + 1'b1) == GOOD_LOCK) begin
              w_state_nxt = ST_SYNC;
              w_miss_nxt  = '0;
            end
          end else if (w_at_start || i_fas) begin
            w_state_nxt = ST_HUNT;
          end else begin
            w_advance = 1'b1;
          end
        end
        ST_SYNC: begin
          if (w_at_start && !i_fas && ((r_miss + 1'b1) == MISS_LOSS)) begin
            w_state_nxt = ST_HUNT;
          end else begin
            w_advance = 1'b1;
            if (w_at_start) w_miss_nxt = i_fas ? '0 : r_miss + 1'b1;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_HUNT;
      r_good  <= '0;
      r_miss  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_miss  <= w_miss_nxt;
      if (i_valid) begin
        if (!w_advance) begin
          r_row <= '0;
          r_col <= '0;
        end else if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_sync = (r_state == ST_SYNC);

endmodule

// File: rtl/frame_demapper.sv
// Frame demapper top: CRC-8 row check, payload gating while aligned, and a
// saturating CRC error counter around the position/alignment tracker.
module frame_demapper
  import frame_demap_pkg::*;
#(
  parameter  int ROWS    = 4,
  parameter  int COLS    = 1024,
  parameter  int OH_COLS = 2,
  parameter  int SYNC_M  = 2,
  parameter  int LOSS_N  = 3,
  parameter  int CNT_W   = 16,
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W   = $clog2(COLS)
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_frame_data,
  input  logic             i_frame_data_valid,
  input  logic             i_frame_data_fas,
  input  logic             i_err_cnt_clr,
  output logic [7:0]       o_pyld_data,
  output logic             o_pyld_data_valid,
  output logic             o_crc_err,
  output logic [7:0]       o_crc_val,
  output logic [CNT_W-1:0] o_crc_err_cnt,
  output logic             o_sync,
  output logic [ROW_W-1:0] o_row_cnt,
  output logic [COL_W-1:0] o_col_cnt
);

  localparam logic [COL_W-1:0] PYLD_FIRST = COL_W'(OH_COLS);
  localparam logic [COL_W-1:0] PYLD_LAST  = COL_W'(COLS - 2);
  localparam logic [COL_W-1:0] CRC_COL    = COL_W'(COLS - 1);

  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic             w_sync;
  logic             w_pyld_col;
  logic             w_crc_col;
  logic             w_crc_mis;

  logic [7:0]       r_crc;
  logic [7:0]       r_pyld_data;
  logic             r_pyld_valid;
  logic             r_crc_err;
  logic [7:0]       r_crc_val;
  logic [CNT_W-1:0] r_err_cnt;
  logic [ROW_W-1:0] r_row_cnt;
  logic [COL_W-1:0] r_col_cnt;

  frame_pos_sync #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .SYNC_M (SYNC_M),
    .LOSS_N (LOSS_N),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_pos_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_frame_data_valid),
    .i_fas   (i_frame_data_fas),
    .o_row   (w_row),
    .o_col   (w_col),
    .o_sync  (w_sync)
  );

  assign w_pyld_col = (w_col >= PYLD_FIRST) && (w_col <= PYLD_LAST);
  assign w_crc_col  = (w_col == CRC_COL);
  // The byte that drops lock sits at col 0 (overhead), so SYNC gating alone stops output.
  assign w_crc_mis  = i_frame_data_valid && w_sync && w_crc_col && (i_frame_data != r_crc);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc        <= CRC_INIT;
      r_pyld_data  <= '0;
      r_pyld_valid <= 1'b0;
      r_crc_err    <= 1'b0;
      r_crc_val    <= '0;
      r_row_cnt    <= '0;
      r_col_cnt    <= '0;
    end else begin
      r_pyld_valid <= 1'b0;
      r_crc_err    <= 1'b0;
      if (i_frame_data_valid) begin
        r_row_cnt <= w_row;
        r_col_cnt <= w_col;
        if (w_col == '0) begin
          r_crc <= CRC_INIT;
        end else if (w_pyld_col) begin
          r_crc <= crc8_next(r_crc, i_frame_data);
        end
        if (w_sync && w_pyld_col) begin
          r_pyld_valid <= 1'b1;
          r_pyld_data  <= i_frame_data;
        end
        if (w_sync && w_crc_col) begin
          r_crc_val <= r_crc;
          r_crc_err <= w_crc_mis;
        end
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (i_err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (w_crc_mis && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_pyld_data       = r_pyld_data;
  assign o_pyld_data_valid = r_pyld_valid;
  assign o_crc_err         = r_crc_err;
  assign o_crc_val         = r_crc_val;
  assign o_crc_err_cnt     = r_err_cnt;
  assign o_sync            = w_sync;
  assign o_row_cnt         = r_row_cnt;
  assign o_col_cnt         = r_col_cnt;

endmodule

// File: tb/tb_frame_demapper.sv
// Self-checking bench for frame_demapper: directed scenarios with random
// payload, compared every cycle against a frame-level reference model.
module tb_frame_demapper;

  localparam int ROWS    = 2;
  localparam int COLS    = 8;
  localparam int OH_COLS = 2;
  localparam int SYNC_M  = 2;
  localparam int LOSS_N  = 2;
  localparam int CNT_W   = 4;
  localparam int FRAME   = ROWS * COLS;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic [7:0]       i_frame_data = '0;
  logic             i_frame_data_valid = 1'b0;
  logic             i_frame_data_fas = 1'b0;
  logic             i_err_cnt_clr = 1'b0;
  logic [7:0]       o_pyld_data;
  logic             o_pyld_data_valid;
  logic             o_crc_err;
  logic [7:0]       o_crc_val;
  logic [CNT_W-1:0] o_crc_err_cnt;
  logic             o_sync;
  logic [0:0]       o_row_cnt;
  logic [2:0]       o_col_cnt;

  int checks   = 0;
  int failures = 0;

  frame_demapper #(
    .ROWS(ROWS), .COLS(COLS), .OH_COLS(OH_COLS),
    .SYNC_M(SYNC_M), .LOSS_N(LOSS_N), .CNT_W(CNT_W)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_frame_data       (i_frame_data),
    .i_frame_data_valid (i_frame_data_valid),
    .i_frame_data_fas   (i_frame_data_fas),
    .i_err_cnt_clr      (i_err_cnt_clr),
    .o_pyld_data        (o_pyld_data),
    .o_pyld_data_valid  (o_pyld_data_valid),
    .o_crc_err          (o_crc_err),
    .o_crc_val          (o_crc_val),
    .o_crc_err_cnt      (o_crc_err_cnt),
    .o_sync             (o_sync),
    .o_row_cnt          (o_row_cnt),
    .o_col_cnt          (o_col_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: alignment tracked as a linear byte index into the frame.
  localparam int M_HUNT = 0, M_PRE = 1, M_SYNC = 2;
  int         m_state, m_pos, m_good, m_miss, m_cnt, m_n;
  logic [7:0] m_buf [0:7];
  logic [7:0] m_crc_val, exp_pd;
  logic       exp_pv, exp_err, exp_sync;
  int         exp_row, exp_col;

  // CRC as polynomial remainder of the message augmented with 8 zero bits.
  function automatic logic [7:0] crc_of(input logic [7:0] a [0:7], input int n);
    int rem = 0;
    for (int i = 0; i < n + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        rem = (rem << 1) | ((i < n) ? int'(a[i][b]) : 0);
        if ((rem & 'h100) != 0) rem = rem ^ 'h107;
      end
    end
    return 8'(rem);
  endfunction

  task automatic model_reset();
    m_state = M_HUNT; m_pos = 0; m_good = 0; m_miss = 0; m_cnt = 0; m_n = 0;
    m_crc_val = '0; exp_pd = '0; exp_pv = 0; exp_err = 0; exp_sync = 0;
    exp_row = 0; exp_col = 0;
  endtask

  task automatic model_step(input logic v, input logic f, input logic [7:0] d, input logic clr);
    int row, col;
    bit in_sync, at_start;
    exp_pv  = 0;
    exp_err = 0;
    if (v) begin
      row = m_pos / COLS;
      col = m_pos % COLS;
      exp_row = row;
      exp_col = col;
      in_sync  = (m_state == M_SYNC);
      at_start = (m_pos == 0);
      if (col == 0) m_n = 0;
      if (col >= OH_COLS && col <= COLS - 2) begin
        m_buf[m_n] = d;
        m_n++;
        if (in_sync) begin exp_pv = 1; exp_pd = d; end
      end
      if (col == COLS - 1 && in_sync) begin
        m_crc_val = crc_of(m_buf, m_n);
        exp_err   = (d != m_crc_val);
      end
      case (m_state)
        M_HUNT: if (f) begin
          m_good = 1; m_miss = 0; m_pos = 1;
          m_state = (SYNC_M == 1) ? M_SYNC : M_PRE;
        end else m_pos = 0;
        M_PRE: if (at_start && f) begin
          m_good++;
          if (m_good == SYNC_M) begin m_state = M_SYNC; m_miss = 0; end
          m_pos = 1;
        end else if (at_start || f) begin
          m_state = M_HUNT; m_pos = 0;
        end else m_pos = (m_pos + 1) % FRAME;
        default: begin
          if (at_start) m_miss = f ? 0 : m_miss + 1;
          if (m_miss == LOSS_N) begin m_state = M_HUNT; m_pos = 0; end
          else m_pos = (m_pos + 1) % FRAME;
        end
      endcase
    end
    if (clr) m_cnt = 0;
    else if (exp_err && m_cnt < CNT_MAX) m_cnt++;
    exp_sync = (m_state == M_SYNC);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    check("sync", 16'(o_sync), 16'(exp_sync));
    check("pyld_valid", 16'(o_pyld_data_valid), 16'(exp_pv));
    if (exp_pv) check("pyld_data", 16'(o_pyld_data), 16'(exp_pd));
    check("crc_err", 16'(o_crc_err), 16'(exp_err));
    check("crc_val", 16'(o_crc_val), 16'(m_crc_val));
    check("err_cnt", 16'(o_crc_err_cnt), 16'(m_cnt));
    check("row_cnt", 16'(o_row_cnt), 16'(exp_row));
    check("col_cnt", 16'(o_col_cnt), 16'(exp_col));
  endtask

  task automatic cyc(input logic v, input logic f, input logic [7:0] d, input logic clr);
    i_frame_data_valid = v;
    i_frame_data_fas   = f;
    i_frame_data       = d;
    i_err_cnt_clr      = clr;
    model_step(v, f, d, clr);
    @(posedge i_clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
  endtask

  task automatic apply_reset();
    i_frame_data_valid = 1'b0;
    i_err_cnt_clr      = 1'b0;
    i_rst = 1'b1;
    #1;
    model_reset();
    check("rst_pyld_data", 16'(o_pyld_data), 16'h0);
    check_outputs();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  // One frame (or its first n_bytes): FAS at col 0 if fas0, an extra FAS at
  // fas_col of row 0, rows in bad_rows get a corrupted CRC byte.
  task automatic send_frame(input bit fas0, input int fas_col, input bit [1:0] bad_rows,
                            input bit gaps, input bit seq, input bit clr_err, input int n_bytes);
    logic [7:0] pay [0:7];
    int         np;
    logic [7:0] d, sv;
    bit         f, c_clr;
    sv = 8'h01;
    for (int r = 0; r < ROWS; r++) begin
      np = 0;
      for (int c = 0; c < COLS; c++) begin
        if (r * COLS + c >= n_bytes) return;
        if (c >= OH_COLS && c <= COLS - 2) begin
          d = seq ? sv : 8'($urandom);
          sv++;
          pay[np] = d;
          np++;
        end else if (c == COLS - 1) begin
          d = crc_of(pay, np) ^ (bad_rows[r] ? 8'hA5 : 8'h00);
        end else begin
          d = 8'($urandom);
        end
        f     = (r == 0) && ((c == 0 && fas0) || c == fas_col);
        c_clr = clr_err && bad_rows[r] && (c == COLS - 1);
        if (gaps) for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) idle();
        cyc(1'b1, f, d, c_clr);
        if (c_clr) cyc(1'b0, 1'b0, 8'h00, 1'b1);
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    apply_reset();
    for (int i = 0; i < 3; i++) idle();

    // Lock over two frames with counting payload.
    send_frame(1, -1, 2'b00, 0, 1, 0, FRAME);
    check("sync_after_first_fas", 16'(o_sync), 16'h0);
    send_frame(1, -1, 2'b00, 0, 1, 0, FRAME);
    check("sync_locked", 16'(o_sync), 16'h1);

    // Single CRC error on row 1.
    send_frame(1, -1, 2'b10, 0, 0, 0, FRAME);
    check("cnt_after_one_err", 16'(o_crc_err_cnt), 16'h1);

    // One miss then FAS keeps lock; two consecutive misses lose it.
    send_frame(0, -1, 2'b00, 0, 0, 0, FRAME);
    send_frame(1, -1, 2'b00, 0, 0, 0, FRAME);
    check("sync_kept_single_miss", 16'(o_sync), 16'h1);
    send_frame(0, -1, 2'b00, 0, 0, 0, FRAME);
    send_frame(0, -1, 2'b00, 0, 0, 0, FRAME);
    check("sync_lost", 16'(o_sync), 16'h0);

    // False FAS at col 3 while in PRESYNC, then re-lock.
    send_frame(1, 3, 2'b00, 0, 0, 0, FRAME);
    check("sync_false_fas", 16'(o_sync), 16'h0);
    send_frame(1, -1, 2'b00, 0, 0, 0, FRAME);
    send_frame(1, -1, 2'b00, 0, 0, 0, FRAME);
    check("sync_relock", 16'(o_sync), 16'h1);

    // Saturation, then clear coinciding with an error.
    for (int i = 0; i < 16; i++) send_frame(1, -1, 2'b01, 0, 0, 0, FRAME);
    check("cnt_saturated", 16'(o_crc_err_cnt), 16'(CNT_MAX));
    send_frame(1, -1, 2'b10, 0, 0, 1, FRAME);
    check("cnt_clr_wins", 16'(o_crc_err_cnt), 16'h0);

    // Reset mid-row, then re-lock with random gaps and random errors.
    send_frame(1, -1, 2'b00, 0, 0, 0, 5);
    apply_reset();
    send_frame(1, -1, 2'b00, 1, 0, 0, FRAME);
    check("sync_post_reset_first", 16'(o_sync), 16'h0);
    send_frame(1, -1, 2'b00, 1, 0, 0, FRAME);
    check("sync_post_reset_relock", 16'(o_sync), 16'h1);
    for (int i = 0; i < 6; i++) send_frame(1, -1, 2'($urandom), 1, 0, 0, FRAME);
    for (int i = 0; i < 4; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
